// File: rtl/pdm_pkg.sv
// Shared types and default widths for the PDM clock generator and its capture path.
package pdm_pkg;

    localparam int DEF_DIV_W  = 16;
    localparam int DEF_SAMP_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

endpackage

// File: rtl/pdm_deser.sv
// Serial-to-parallel capture of one PDM channel: shifts a bit in MSB first on each strobe
// and presents a completed word with a one-cycle valid pulse.
module pdm_deser #(
    parameter int SAMP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clr,
    input  logic              i_stb,
    input  logic              i_din,
    output logic [SAMP_W-1:0] o_data,
    output logic              o_valid
);

    localparam int CNT_W = $clog2(SAMP_W) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SAMP_W - 1);

    logic [SAMP_W-1:0] r_shift;
    logic [SAMP_W-1:0] r_data;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_valid;
    logic [SAMP_W-1:0] w_word;

    assign w_word = {r_shift[SAMP_W-2:0], i_din};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift <= '0;
            r_data  <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (i_clr) begin
                r_cnt <= '0;
            end else if (i_stb) begin
                r_shift <= w_word;
                if (r_cnt == LAST_BIT) begin
                    r_data  <= w_word;
                    r_valid <= 1'b1;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule

// File: rtl/pdm_clk_gen.sv
// Programmable 50%-duty PDM clock generator with glitch-free stop and period-aligned divisor updates.
// Optional stereo capture path is built only when PDM_CLK_GEN_CAPTURE_EN is defined.
module pdm_clk_gen
    import pdm_pkg::*;
#(
    parameter int DIV_W    = DEF_DIV_W,
    parameter int DEF_HALF = 2,
    parameter int MIN_HALF = 1,
    parameter int SAMP_W   = DEF_SAMP_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [DIV_W-1:0]  div_data,
    input  logic              div_valid,
    output logic              div_ready,
    output logic              clkout,
    output logic              rise_stb,
    output logic              fall_stb,
    output logic              active,
    input  logic              pdm_in,
    output logic [SAMP_W-1:0] data_l,
    output logic [SAMP_W-1:0] data_r,
    output logic              valid_l,
    output logic              valid_r
);

    localparam logic [DIV_W-1:0] L_MIN_HALF = DIV_W'(MIN_HALF);
    localparam logic [DIV_W-1:0] L_DEF_HALF = DIV_W'(DEF_HALF);

    state_t           r_state, w_state_nxt;
    logic [DIV_W-1:0] r_cnt, w_cnt_nxt;
    logic [DIV_W-1:0] r_half, w_half_nxt;
    logic [DIV_W-1:0] r_pend, w_pend_nxt;
    logic             r_pend_vld, w_pend_vld_nxt;
    logic             r_clkout, w_clkout_nxt;
    logic             r_rise, w_rise_nxt;
    logic             r_fall, w_fall_nxt;

    logic             w_hs;
    logic [DIV_W-1:0] w_div_clamped;
    logic [DIV_W-1:0] w_apply_half;

    assign w_hs          = div_valid & div_ready;
    assign w_div_clamped = (div_data < L_MIN_HALF) ? L_MIN_HALF : div_data;
    // A value accepted on the boundary cycle itself is applied right away rather than parked.
    assign w_apply_half  = r_pend_vld ? r_pend : (w_hs ? w_div_clamped : r_half);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_half     <= L_DEF_HALF;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_clkout   <= 1'b0;
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_half     <= w_half_nxt;
            r_pend     <= w_pend_nxt;
            r_pend_vld <= w_pend_vld_nxt;
            r_clkout   <= w_clkout_nxt;
            r_rise     <= w_rise_nxt;
            r_fall     <= w_fall_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_half_nxt     = r_half;
        w_pend_nxt     = r_pend;
        w_pend_vld_nxt = r_pend_vld;
        w_clkout_nxt   = r_clkout;
        w_rise_nxt     = 1'b0;
        w_fall_nxt     = 1'b0;

        case (r_state)
            IDLE: begin
                w_cnt_nxt    = '0;
                w_clkout_nxt = 1'b0;
                if (w_hs) begin
                    w_half_nxt = w_div_clamped;
                end
                if (enable) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = (w_hs ? w_div_clamped : r_half) - 1'b1;
                end
            end

            RUN, STOP: begin
                if (w_hs) begin
                    w_pend_nxt     = w_div_clamped;
                    w_pend_vld_nxt = 1'b1;
                end
                if (r_state == RUN && !enable && !r_clkout) begin
                    w_state_nxt    = IDLE;
                    w_cnt_nxt      = '0;
                    w_half_nxt     = w_apply_half;
                    w_pend_vld_nxt = 1'b0;
                end else if (r_cnt == '0) begin
                    w_clkout_nxt = ~r_clkout;
                    if (r_clkout) begin
                        // Falling edge closes the period: the only safe point to change half.
                        w_fall_nxt     = 1'b1;
                        w_half_nxt     = w_apply_half;
                        w_pend_vld_nxt = 1'b0;
                        if (enable) begin
                            w_state_nxt = RUN;
                            w_cnt_nxt   = w_apply_half - 1'b1;
                        end else begin
                            w_state_nxt = IDLE;
                            w_cnt_nxt   = '0;
                        end
                    end else begin
                        w_rise_nxt = 1'b1;
                        w_cnt_nxt  = r_half - 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                    if (r_state == RUN && !enable) begin
                        w_state_nxt = STOP;
                    end else if (r_state == STOP && enable) begin
                        w_state_nxt = RUN;
                    end
                end
            end

            default: begin
                w_state_nxt  = IDLE;
                w_cnt_nxt    = '0;
                w_clkout_nxt = 1'b0;
            end
        endcase
    end

    assign div_ready = ~r_pend_vld;
    assign clkout    = r_clkout;
    assign rise_stb  = r_rise;
    assign fall_stb  = r_fall;
    assign active    = (r_state != IDLE);

`ifdef PDM_CLK_GEN_CAPTURE_EN
    logic w_clr;

    assign w_clr = (r_state == IDLE);

    pdm_deser #(.SAMP_W(SAMP_W)) u_deser_l (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (w_clr),
        .i_stb   (r_fall),
        .i_din   (pdm_in),
        .o_data  (data_l),
        .o_valid (valid_l)
    );

    pdm_deser #(.SAMP_W(SAMP_W)) u_deser_r (
        .clk     (clk),
        .reset   (reset),
        .i_clr   (w_clr),
        .i_stb   (r_rise),
        .i_din   (pdm_in),
        .o_data  (data_r),
        .o_valid (valid_r)
    );
`else
    logic w_unused_pdm;

    assign w_unused_pdm = pdm_in;
    assign data_l       = '0;
    assign data_r       = '0;
    assign valid_l      = 1'b0;
    assign valid_r      = 1'b0;
`endif

endmodule

// File: tb/tb_pdm_clk_gen.sv
// Self-checking bench for pdm_clk_gen: a per-cycle vector table for the basic run/stop
// sequence, then directed sequences for stop, divisor update, clamp, async reset and capture.
module tb_pdm_clk_gen;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        enable    = 1'b0;
    logic        div_valid = 1'b0;
    logic [15:0] div_data  = '0;
    logic        capMode   = 1'b0;
    logic        pdm_in;
    logic        div_ready, clkout, rise_stb, fall_stb, active;
    logic [7:0]  data_l, data_r;
    logic        valid_l, valid_r;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       en;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs [11];

    assign pdm_in = capMode ? clkout : 1'b0;

    pdm_clk_gen dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .div_data  (div_data),
        .div_valid (div_valid),
        .div_ready (div_ready),
        .clkout    (clkout),
        .rise_stb  (rise_stb),
        .fall_stb  (fall_stb),
        .active    (active),
        .pdm_in    (pdm_in),
        .data_l    (data_l),
        .data_r    (data_r),
        .valid_l   (valid_l),
        .valid_r   (valid_r)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic en, input logic dv, input logic [15:0] dd);
        enable    = en;
        div_valid = dv;
        div_data  = dd;
        stepClk();
    endtask

    function automatic logic sigOf(input int which);
        case (which)
            0:       return rise_stb;
            1:       return fall_stb;
            2:       return valid_r;
            default: return ~active;
        endcase
    endfunction

    // Steps at least one cycle, then until the selected signal is seen or the budget runs out.
    task automatic waitSig(input int which, input int budget, output logic ok);
        int n = 0;
        do begin
            stepClk();
            n++;
        end while (!sigOf(which) && n < budget);
        ok = sigOf(which);
    endtask

    task automatic countTo(input int which, input int budget, output int n);
        n = 0;
        do begin
            stepClk();
            n++;
        end while (!sigOf(which) && n < budget);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic ok;
        int   n;
        int   rises;
        logic anyCap;

        // Expected {clkout, rise_stb, fall_stb, active, div_ready} after each edge at half=2.
        vecs[0]  = '{1'b1, 5'b00011};
        vecs[1]  = '{1'b1, 5'b00011};
        vecs[2]  = '{1'b1, 5'b11011};
        vecs[3]  = '{1'b1, 5'b10011};
        vecs[4]  = '{1'b1, 5'b00111};
        vecs[5]  = '{1'b1, 5'b00011};
        vecs[6]  = '{1'b1, 5'b11011};
        vecs[7]  = '{1'b1, 5'b10011};
        vecs[8]  = '{1'b1, 5'b00111};
        vecs[9]  = '{1'b0, 5'b00001};
        vecs[10] = '{1'b0, 5'b00001};

        #1 reset = 1'b0;
        #2;
        checkOutput("reset_state", {27'd0, clkout, rise_stb, fall_stb, active, div_ready}, 32'h1);
        checkOutput("reset_capture", {14'd0, data_l, data_r, valid_l, valid_r}, 32'h0);
        #9 reset = 1'b1;

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].en, 1'b0, 16'd0);
            checkOutput($sformatf("vec%0d", i),
                        {27'd0, clkout, rise_stb, fall_stb, active, div_ready},
                        {27'd0, vecs[i].exp});
        end

        // Stop one cycle into the high phase at half=4.
        applyStimulus(1'b0, 1'b1, 16'd4);
        div_valid = 1'b0;
        enable    = 1'b1;
        waitSig(0, 64, ok);
        checkOutput("stop_rise_seen", {31'd0, ok}, 32'd1);
        applyStimulus(1'b0, 1'b0, 16'd0);
        checkOutput("stop_active", {31'd0, active}, 32'd1);
        n = 0;
        while (clkout === 1'b1 && n < 20) begin
            n++;
            stepClk();
        end
        checkOutput("stop_high_cycles", n, 32'd3);
        checkOutput("stop_end", {29'd0, clkout, fall_stb, active}, 32'b010);

        // Divisor 5 loaded during the high phase at half=2.
        applyStimulus(1'b0, 1'b1, 16'd2);
        div_valid = 1'b0;
        enable    = 1'b1;
        waitSig(0, 64, ok);
        checkOutput("upd_rise_seen", {31'd0, ok}, 32'd1);
        checkOutput("upd_ready_before", {31'd0, div_ready}, 32'd1);
        applyStimulus(1'b1, 1'b1, 16'd5);
        div_valid = 1'b0;
        checkOutput("upd_ready_pending", {30'd0, div_ready, clkout}, 32'b01);
        stepClk();
        checkOutput("upd_fall_ready", {30'd0, fall_stb, div_ready}, 32'b11);
        countTo(0, 64, n);
        checkOutput("upd_low_phase", n, 32'd5);
        countTo(1, 64, n);
        checkOutput("upd_high_phase", n, 32'd5);

        // Divisor 0 clamps to 1.
        applyStimulus(1'b1, 1'b1, 16'd0);
        div_valid = 1'b0;
        waitSig(1, 64, ok);
        waitSig(0, 64, ok);
        checkOutput("clamp_rise_seen", {31'd0, ok}, 32'd1);
        countTo(0, 64, n);
        checkOutput("clamp_period", n, 32'd2);

        // Async reset during the high phase with a divisor pending.
        waitSig(1, 64, ok);
        applyStimulus(1'b1, 1'b1, 16'd3);
        div_valid = 1'b0;
        checkOutput("rst_pre", {30'd0, clkout, div_ready}, 32'b10);
        #2 reset = 1'b0;
        #1;
        checkOutput("rst_async", {28'd0, clkout, div_ready, active, rise_stb}, 32'b0100);
        enable = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // Capture path: pdm_in follows clkout, so right samples 1s and left samples 0s.
        capMode = 1'b1;
        enable  = 1'b1;
`ifdef PDM_CLK_GEN_CAPTURE_EN
        rises = 0;
        n     = 0;
        do begin
            stepClk();
            n++;
            if (rise_stb) rises++;
        end while (!valid_r && n < 200);
        checkOutput("cap_valid_r", {31'd0, valid_r}, 32'd1);
        checkOutput("cap_rises", rises, 32'd8);
        checkOutput("cap_data_r", {24'd0, data_r}, 32'hFF);
        waitSig(1, 64, ok);
        stepClk();
        checkOutput("cap_valid_l", {31'd0, valid_l}, 32'd1);
        checkOutput("cap_data_l", {24'd0, data_l}, 32'h00);
        stepClk();
        checkOutput("cap_pulse_width", {30'd0, valid_l, valid_r}, 32'd0);
`else
        anyCap = 1'b0;
        for (int i = 0; i < 80; i++) begin
            stepClk();
            if ({data_l, data_r, valid_l, valid_r} !== '0) anyCap = 1'b1;
        end
        checkOutput("cap_tied_zero", {31'd0, anyCap}, 32'd0);
        rises = 0;
`endif
        capMode = 1'b0;
        enable  = 1'b0;
        waitSig(3, 64, ok);
        checkOutput("final_idle", {31'd0, ok}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pdm_clk_gen.md
PDM_CLK_GEN -- requirements
Module: pdm_clk_gen

Interface
REQ-001 SHALL have parameter DIV_W, default 16: width of half-period divisor.
REQ-002 SHALL have parameter DEF_HALF, default 2: half-period, in clk cycles, loaded at reset.
REQ-003 SHALL have parameter MIN_HALF, default 1: smallest legal half-period.
REQ-004 SHALL have parameter SAMP_W, default 8: bits per captured channel word.
REQ-005 SHALL have clk  input  1: single clock; all logic on its rising edge.
REQ-006 SHALL have reset  input  1: asynchronous, active-low reset.
REQ-007 SHALL have enable  input  1: level request to run the output clock.
REQ-008 SHALL have div_data  input  DIV_W: new half-period value.
REQ-009 SHALL have div_valid  input  1 and div_ready  output  1: divisor load handshake.
REQ-010 SHALL have clkout  output  1: generated PDM clock, registered.
REQ-011 SHALL have rise_stb / fall_stb  output  1 each: one-cycle pulses on the clkout 0->1 / 1->0 update cycle.
REQ-012 SHALL have active  output  1: high in RUN and STOP.
REQ-013 SHALL have pdm_in  input  1, data_l / data_r  output  SAMP_W, valid_l / valid_r  output  1 (capture port; see Configuration).

Function
REQ-014 SHALL implement states IDLE, RUN, STOP.
REQ-015 SHALL, in IDLE with enable=1, enter RUN the next cycle with cnt=half-1 and clkout=0.
REQ-016 SHALL, in RUN, decrement cnt each cycle; at cnt=0 toggle clkout and reload half-1, giving a period of 2*half cycles and 50% duty.
REQ-017 SHALL, when enable=0 in RUN: with clkout=0 go to IDLE immediately; with clkout=1 go to STOP and finish the high phase, then IDLE with clkout=0 (no runt pulse).
REQ-018 SHALL, if enable returns to 1 during STOP, complete the high phase and resume RUN without passing through IDLE.
REQ-019 SHALL hold div_ready=1 in IDLE; a handshake there updates half on the next cycle.
REQ-020 SHALL, on a handshake in RUN/STOP, store div_data as pending, drop div_ready, and apply it at the next 1->0 toggle (period boundary); div_ready then returns to 1.
REQ-021 SHALL clamp any accepted value below MIN_HALF (including 0) to MIN_HALF.
REQ-022 SHALL give priority to the disable path over divisor apply when both fall on the same boundary; pending is still applied.
REQ-023 SHALL assert rise_stb/fall_stb in the same cycle that clkout changes; both are 0 in IDLE.

Reset
REQ-024 SHALL, on reset=0, asynchronously force IDLE, clkout=0, strobes=0, active=0, cnt=0, half=DEF_HALF, pending cleared, div_ready=1, data/valid outputs 0.
REQ-025 SHALL, on reset asserted mid-period, drop clkout to 0 without waiting for a boundary.

Configuration
REQ-026 SHALL compile the capture path only under macro PDM_CLK_GEN_CAPTURE_EN.
REQ-027 SHALL, with the macro, shift pdm_in into the left shift register on fall_stb and the right on rise_stb (MSB first), and pulse valid_l/valid_r for one cycle with the completed word every SAMP_W bits; both bit counters clear on entry to IDLE.
REQ-028 SHALL, without the macro, tie data_l/data_r/valid_l/valid_r to 0 and leave pdm_in unused.

Structure
REQ-029 SHALL place the state enum and the default DIV_W/SAMP_W constants in package pdm_pkg.
REQ-030 SHALL implement the capture path as sub-module pdm_deser, instantiated twice (left and right).

Verification
REQ-031 SHALL cover: reset, enable=1, half=2 -> first rise_stb 2 cycles after RUN entry, clkout period 4, 50% duty.
REQ-032 SHALL cover: enable dropped 1 cycle into the high phase at half=4 -> clkout stays high 3 more cycles, then IDLE, clkout=0.
REQ-033 SHALL cover: div_data=5 loaded mid-RUN at half=2 -> div_ready=0 until the next fall_stb, then period 10 from that boundary.
REQ-034 SHALL cover: div_data=0 handshake -> half=MIN_HALF=1, period 2.
REQ-035 SHALL cover: reset pulled low with clkout=1 -> clkout=0 and div_ready=1 immediately.
REQ-036 SHALL cover (macro on, SAMP_W=8): pdm_in alternating 1/0 per edge -> data_l=8'h00, data_r=8'hFF, valid pulses after 8 clkout periods.
